// File: rtl/anabellek_denetleyici_pkg.sv
// Shared definitions for the main-memory controller: FSM state encodings
// and default bus widths used by the interfaces and the controller.
package anabellek_denetleyici_pkg;

  localparam int ADRES_BIT_VARSAYILAN = 32;
  localparam int VERI_BIT_VARSAYILAN  = 32;
  localparam int OBEK_BIT_VARSAYILAN  = 128;

  typedef enum logic [1:0] {
    BOSTA     = 2'd0,
    YAZ_VURUS = 2'd1,
    OKU_VURUS = 2'd2,
    TAMAM     = 2'd3
  } durum_t;

endpackage

// File: rtl/anabellek_denetleyici_if.sv
// Bus bundles for the controller: the cache-miss request side and the
// word-wide external memory beat side. The cache (or bench) is master of
// the request bundle; the controller is master of the memory bundle.
interface anabellek_onbellek_if
  import anabellek_denetleyici_pkg::*;
#(
  parameter int ADRES_BIT = ADRES_BIT_VARSAYILAN,
  parameter int OBEK_BIT  = OBEK_BIT_VARSAYILAN
);
  logic                 istek;
  logic                 yaz;
  logic                 oku;
  logic [ADRES_BIT-1:0] adres;
  logic [OBEK_BIT-1:0]  kirli_obek;
  logic                 musait;
  logic                 hazir;
  logic [OBEK_BIT-1:0]  obek;

  modport master (output istek, yaz, oku, adres, kirli_obek,
                  input  musait, hazir, obek);
  modport slave  (input  istek, yaz, oku, adres, kirli_obek,
                  output musait, hazir, obek);
endinterface

interface anabellek_bellek_if
  import anabellek_denetleyici_pkg::*;
#(
  parameter int ADRES_BIT = ADRES_BIT_VARSAYILAN,
  parameter int VERI_BIT  = VERI_BIT_VARSAYILAN
);
  logic                 istek;
  logic                 yaz;
  logic [ADRES_BIT-1:0] adres;
  logic [VERI_BIT-1:0]  veri_yaz;
  logic [VERI_BIT-1:0]  veri_oku;
  logic                 gecerli;

  modport master (output istek, yaz, adres, veri_yaz,
                  input  veri_oku, gecerli);
  modport slave  (input  istek, yaz, adres, veri_yaz,
                  output veri_oku, gecerli);
endinterface

// File: rtl/anabellek_denetleyici_sayac.sv
// anabellek_sayac: enabled up-counter that wraps naturally at 2^W and
// clears on synchronous reset. Used for the optional block statistics.
module anabellek_sayac #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] deger_o
);

  logic [W-1:0] sayi_q, sayi_d;

  // Next count: step by one when enabled, otherwise hold.
  always_comb begin
    sayi_d = sayi_q;
    if (en_i) sayi_d = sayi_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) sayi_q <= '0;
    else       sayi_q <= sayi_d;
  end

  assign deger_o = sayi_q;

endmodule

// File: rtl/anabellek_denetleyici.sv
// anabellek_denetleyici: main-memory controller behind the data cache.
// A block request is split into word beats on the external bus, each beat
// held until acknowledged; completion is signalled with a one-cycle hazir.
// Optional macro ANABELLEK_SAYAC_EN adds completed read/write block counters.
module anabellek_denetleyici
  import anabellek_denetleyici_pkg::*;
#(
  parameter int ADRES_BIT = ADRES_BIT_VARSAYILAN,
  parameter int VERI_BIT  = VERI_BIT_VARSAYILAN,
  parameter int OBEK_BIT  = OBEK_BIT_VARSAYILAN
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  anabellek_onbellek_if.slave     onb,
  anabellek_bellek_if.master      bel
`ifdef ANABELLEK_SAYAC_EN
  ,
  output logic [31:0]             anabellek_oku_sayisi_o,
  output logic [31:0]             anabellek_yaz_sayisi_o
`endif
);

  localparam int VURUS_SAYISI = OBEK_BIT / VERI_BIT;
  localparam int SAYAC_BIT    = (VURUS_SAYISI > 1) ? $clog2(VURUS_SAYISI) : 1;
  localparam int KELIME_KAYMA = $clog2(VERI_BIT / 8);
  localparam logic [ADRES_BIT-1:0] HIZA_MASKE = ADRES_BIT'((OBEK_BIT / 8) - 1);
  localparam logic [SAYAC_BIT-1:0] SON_VURUS  = SAYAC_BIT'(VURUS_SAYISI - 1);

  durum_t               durum_q, durum_d;
  logic [SAYAC_BIT-1:0] vurus_q, vurus_d;
  logic [ADRES_BIT-1:0] taban_q, taban_d;
  logic [OBEK_BIT-1:0]  kirli_q, kirli_d;
  logic [OBEK_BIT-1:0]  okunan_q, okunan_d;
  logic [OBEK_BIT-1:0]  obek_q, obek_d;
  logic                 musait;
  logic                 kabul;
  logic                 aktarim;

  assign musait  = (durum_q == BOSTA) || (durum_q == TAMAM);
  assign aktarim = (durum_q == YAZ_VURUS) || (durum_q == OKU_VURUS);
  // A request that names neither direction is dropped rather than accepted.
  assign kabul   = onb.istek && musait && (onb.yaz || onb.oku);

  // Next-state and datapath update: accept in BOSTA/TAMAM, step beats on ack.
  always_comb begin
    durum_d  = durum_q;
    vurus_d  = vurus_q;
    taban_d  = taban_q;
    kirli_d  = kirli_q;
    okunan_d = okunan_q;
    obek_d   = obek_q;
    case (durum_q)
      YAZ_VURUS, OKU_VURUS: begin
        if (bel.gecerli) begin
          if (durum_q == OKU_VURUS)
            okunan_d[int'(vurus_q)*VERI_BIT +: VERI_BIT] = bel.veri_oku;
          if (vurus_q == SON_VURUS) begin
            durum_d = TAMAM;
            // Publish the whole block at once so obek stays stable between reads.
            if (durum_q == OKU_VURUS) obek_d = okunan_d;
          end else begin
            vurus_d = vurus_q + 1'b1;
          end
        end
      end
      default: begin
        durum_d = BOSTA;
        if (kabul) begin
          taban_d = onb.adres & ~HIZA_MASKE;
          kirli_d = onb.kirli_obek;
          vurus_d = '0;
          // Write-back takes priority when both directions are requested.
          durum_d = onb.yaz ? YAZ_VURUS : OKU_VURUS;
        end
      end
    endcase
  end

  // Control registers and the visible read block, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q <= BOSTA;
      vurus_q <= '0;
      obek_q  <= '0;
    end else begin
      durum_q <= durum_d;
      vurus_q <= vurus_d;
      obek_q  <= obek_d;
    end
  end

  // Working data registers; only meaningful while a transfer is in flight.
  always_ff @(posedge clk_i) begin
    taban_q  <= taban_d;
    kirli_q  <= kirli_d;
    okunan_q <= okunan_d;
  end

  // Bus outputs: address and write data are forced to zero outside beats.
  always_comb begin
    onb.musait   = musait;
    onb.hazir    = (durum_q == TAMAM);
    onb.obek     = obek_q;
    bel.istek    = aktarim;
    bel.yaz      = (durum_q == YAZ_VURUS);
    bel.adres    = '0;
    bel.veri_yaz = '0;
    if (aktarim)
      bel.adres = taban_q + (ADRES_BIT'(vurus_q) << KELIME_KAYMA);
    if (durum_q == YAZ_VURUS)
      bel.veri_yaz = kirli_q[int'(vurus_q)*VERI_BIT +: VERI_BIT];
  end

`ifdef ANABELLEK_SAYAC_EN
  logic son_oku_q, son_oku_d;

  // Remember the direction of the accepted request for the hazir cycle.
  always_comb begin
    son_oku_d = son_oku_q;
    if (kabul) son_oku_d = !onb.yaz;
  end

  // Direction flag register.
  always_ff @(posedge clk_i) begin
    if (rst_i) son_oku_q <= 1'b0;
    else       son_oku_q <= son_oku_d;
  end

  anabellek_sayac #(.W(32)) u_oku_sayac (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    ((durum_q == TAMAM) && son_oku_q),
    .deger_o (anabellek_oku_sayisi_o)
  );

  anabellek_sayac #(.W(32)) u_yaz_sayac (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    ((durum_q == TAMAM) && !son_oku_q),
    .deger_o (anabellek_yaz_sayisi_o)
  );
`endif

endmodule
